data_mem_responder: RTL and testbench

//  - Byte-addressed data memory that answers the datapath's memRead/memWrite load/store requests (LW/LB/LBU/SW/SB, plus half-word).
//  - Is the responder end of the control unit's memory signals.
//  - Multi-cycle: accepts a request, inserts programmable wait states, then returns a one-cycle ready pulse with read data.
//  - Storage is big-endian: byte at addr is the MSB, matching instruction fetch ordering.

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_byte_array.sv | 20 ++
 rtl/data_mem_responder.sv | 93 +++++++++
 tb/tb_data_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and limits for data_mem_responder
package dmem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int MAX_WAIT = 15;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
endpackage

// File: rtl/dmem_byte_array.sv
// dmem_byte_array: DEPTH x 8 storage, four combinational read lanes and four byte-enabled write lanes at base+k wrapping mod DEPTH
module dmem_byte_array #(
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] base_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wd_i,
  output logic [31:0]   rd_o
);
  logic [7:0] mem_q [DEPTH];
  for (genvar k = 0; k < 4; k++) begin : g_rd
    assign rd_o[31-8*k -: 8] = mem_q[base_i + AW'(k)];
  end
  // lane k holds the byte at base+k; lane 0 is the most significant byte
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (we_i[k]) mem_q[base_i + AW'(k)] <= wd_i[31-8*k -: 8];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle big-endian data memory answering load/store requests with a one-cycle ready pulse
// Optional DMEM_ALIGN_CHECK_EN: misaligned half/word accesses complete with misalign_err and no storage change.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        un_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES > MAX_WAIT ? MAX_WAIT : WAIT_STATES);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, we;
  logic [AW-1:0] addr_q;
  logic [1:0] size_q;
  logic uns_q, wr_q, ready_q, mis_q, mis, sgn, accept, unused_addr;
  logic [31:0] wdata_q, rdata_q, rd, wd, fmt;
  assign accept = state_q == IDLE && (mem_read || mem_write);
  assign unused_addr = ^addr[31:AW];
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = (size_q == SZ_HALF && addr_q[0]) || (size_q >= SZ_WORD && addr_q[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign we = (state_q == RESP && wr_q && !mis && !reset) ?
              (size_q >= SZ_WORD ? 4'b1111 : size_q == SZ_HALF ? 4'b0011 : 4'b0001) : 4'b0000;
  assign wd = size_q == SZ_BYTE ? {wdata_q[7:0], 24'h0} : size_q == SZ_HALF ? {wdata_q[15:0], 16'h0} : wdata_q;
  assign sgn = rd[31] & ~uns_q;
  assign fmt = size_q == SZ_BYTE ? {{24{sgn}}, rd[31:24]} : size_q == SZ_HALF ? {{16{sgn}}, rd[31:16]} : rd;
  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy = state_q != IDLE;
  assign misalign_err = mis_q;
  dmem_byte_array #(.DEPTH(DEPTH)) u_arr (
    .clk   (clk),
    .base_i(addr_q),
    .we_i  (we),
    .wd_i  (wd),
    .rd_o  (rd)
  );
  // IDLE accepts, WAIT counts down the wait states, RESP completes in one cycle
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (accept) begin
        cnt_d = WS;
        state_d = WS != 4'd0 ? WAIT : RESP;
      end
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = cnt_q == 4'd1 ? RESP : WAIT;
    end else state_d = IDLE;
  end
  // FSM registers and the registered response produced on the RESP edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      ready_q <= 1'b0;
      mis_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      ready_q <= state_q == RESP;
      mis_q <= state_q == RESP && mis;
      rdata_q <= (state_q == RESP && !wr_q && !mis) ? fmt : 32'h0;
    end
  end
  // request fields are captured only on accept so inputs seen while busy are ignored
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr[AW-1:0];
      size_q <= size;
      uns_q <= un_sign;
      wdata_q <= wdata;
      wr_q <= mem_write;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard-driven directed bench for data_mem_responder at wait states 1, 3 and 0
module tb_data_mem_responder;
  import dmem_pkg::*;
  typedef struct packed {logic [31:0] rdata; logic mis;} exp_t;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset [3];
  logic rd [3], wr [3], us [3], ready [3], busy [3], mis [3];
  logic [1:0] sz [3];
  logic [31:0] a [3], wd [3], rdata [3];
  int ws [3] = '{1, 3, 0};
  exp_t sb [$];
  int n_assert = 0, n_fail = 0, cyc = 0, acc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  data_mem_responder #(.DEPTH(512), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset[0]), .mem_read(rd[0]), .mem_write(wr[0]), .size(sz[0]), .un_sign(us[0]),
    .addr(a[0]), .wdata(wd[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .misalign_err(mis[0]));
  data_mem_responder #(.DEPTH(512), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset[1]), .mem_read(rd[1]), .mem_write(wr[1]), .size(sz[1]), .un_sign(us[1]),
    .addr(a[1]), .wdata(wd[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .misalign_err(mis[1]));
  data_mem_responder #(.DEPTH(512), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset[2]), .mem_read(rd[2]), .mem_write(wr[2]), .size(sz[2]), .un_sign(us[2]),
    .addr(a[2]), .wdata(wd[2]), .rdata(rdata[2]), .ready(ready[2]), .busy(busy[2]), .misalign_err(mis[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic issue(input int i, input logic r, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] ad, input logic [31:0] d, input logic [31:0] er, input logic em);
    @(negedge clk);
    rd[i] = r; wr[i] = w; sz[i] = s; us[i] = u; a[i] = ad; wd[i] = d;
    sb.push_back(exp_t'{rdata: er, mis: em});
    @(negedge clk);
    rd[i] = 1'b0; wr[i] = 1'b0;
    acc = cyc;
    chk_b("busy_after_accept", busy[i], 1'b1);
  endtask

  task automatic finish(input int i, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (ready[i] !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk("latency", 32'(cyc - acc), 32'(lat));
    chk("rdata", rdata[i], e.rdata);
    chk_b("misalign", mis[i], e.mis);
    chk_b("busy_at_ready", busy[i], 1'b0);
  endtask

  task automatic op(input int i, input logic r, input logic w, input logic [1:0] s, input logic u,
                    input logic [31:0] ad, input logic [31:0] d, input logic [31:0] er, input logic em);
    issue(i, r, w, s, u, ad, d, er, em);
    finish(i, ws[i] + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int extra;
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; rd[i] = 1'b0; wr[i] = 1'b0; sz[i] = SZ_WORD; us[i] = 1'b0; a[i] = '0; wd[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_rdata", rdata[i], 32'h0);
      chk_b("reset_ready", ready[i], 1'b0);
      chk_b("reset_busy", busy[i], 1'b0);
      chk_b("reset_mis", mis[i], 1'b0);
    end
    // word round trip
    op(0, 0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    op(0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h10, 32'h0, 32'h000000DE, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h11, 32'h0, 32'h000000AD, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h12, 32'h0, 32'h000000BE, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h13, 32'h0, 32'h000000EF, 0);
    // byte and half extension, neighbours untouched
    op(0, 0, 1, SZ_WORD, 0, 32'h20, 32'h11223344, 32'h0, 0);
    op(0, 0, 1, SZ_BYTE, 0, 32'h21, 32'h12345680, 32'h0, 0);
    op(0, 1, 0, SZ_BYTE, 0, 32'h21, 32'h0, 32'hFFFFFF80, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h21, 32'h0, 32'h00000080, 0);
    op(0, 1, 0, SZ_WORD, 0, 32'h20, 32'h0, 32'h11803344, 0);
    op(0, 0, 1, SZ_HALF, 0, 32'h24, 32'h9999ABCD, 32'h0, 0);
    op(0, 1, 0, SZ_HALF, 0, 32'h24, 32'h0, 32'hFFFFABCD, 0);
    op(0, 1, 0, SZ_HALF, 1, 32'h24, 32'h0, 32'h0000ABCD, 0);
    // wrap, unaligned and ignored upper address bits
    op(0, 0, 1, SZ_BYTE, 0, 32'h1FE, 32'h11, 32'h0, 0);
    op(0, 0, 1, SZ_BYTE, 0, 32'h1FF, 32'h22, 32'h0, 0);
    op(0, 0, 1, SZ_BYTE, 0, 32'h000, 32'h33, 32'h0, 0);
    op(0, 0, 1, SZ_BYTE, 0, 32'h001, 32'h44, 32'h0, 0);
    op(0, 1, 0, SZ_WORD, 0, 32'h1FE, 32'h0, ALIGN ? 32'h0 : 32'h11223344, ALIGN);
    op(0, 1, 0, SZ_BYTE, 0, 32'h3FF, 32'h0, 32'h00000022, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'hFFFFFE00, 32'h0, 32'h00000033, 0);
    op(0, 1, 0, SZ_HALF, 1, 32'h1FF, 32'h0, ALIGN ? 32'h0 : 32'h00002233, ALIGN);
    op(0, 0, 1, SZ_HALF, 0, 32'h1FF, 32'hBEEF, 32'h0, ALIGN);
    op(0, 1, 0, SZ_BYTE, 1, 32'h1FF, 32'h0, ALIGN ? 32'h00000022 : 32'h000000BE, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h000, 32'h0, ALIGN ? 32'h00000033 : 32'h000000EF, 0);
    // second request during WAIT is ignored
    issue(0, 1, 0, SZ_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    rd[0] = 1'b1; a[0] = 32'h20;
    @(negedge clk);
    rd[0] = 1'b0;
    finish(0, 2);
    extra = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready[0] === 1'b1) extra++;
    end
    chk("extra_ready", 32'(extra), 32'h0);
    // read and write together is a write
    op(0, 1, 1, SZ_BYTE, 0, 32'h30, 32'h0000005A, 32'h0, 0);
    op(0, 1, 0, SZ_BYTE, 1, 32'h30, 32'h0, 32'h0000005A, 0);
    // reset during WAIT aborts the store
    op(1, 0, 1, SZ_WORD, 0, 32'h40, 32'h01020304, 32'h0, 0);
    issue(1, 0, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
    void'(sb.pop_back());
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    chk_b("busy_after_reset", busy[1], 1'b0);
    extra = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ready[1] === 1'b1) extra++;
    end
    chk("ready_after_abort", 32'(extra), 32'h0);
    op(1, 1, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h01020304, 0);
    // zero wait states, back-to-back reads
    op(2, 0, 1, SZ_WORD, 0, 32'h80, 32'h0BADCAFE, 32'h0, 0);
    @(negedge clk);
    rd[2] = 1'b1; sz[2] = SZ_WORD; a[2] = 32'h80;
    for (int k = 0; k < 3; k++) sb.push_back(exp_t'{rdata: 32'h0BADCAFE, mis: 1'b0});
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_b("b2b_busy", busy[2], k % 2 == 0);
      chk_b("b2b_ready", ready[2], k % 2 == 1);
      if (k % 2 == 1) begin
        e = sb.pop_front();
        chk("b2b_rdata", rdata[2], e.rdata);
      end
    end
    rd[2] = 1'b0;
    repeat (2) @(negedge clk);
    chk_b("b2b_idle", busy[2], 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
